// File: rtl/rs_slot_alloc_pkg.sv
// rs_slot_alloc_pkg: shared reservation-station defaults, derived widths and the op encoding used around them.
package rs_slot_alloc_pkg;
   localparam int RS_DEPTH  = 8;
   localparam int RS_MARGIN = 1;
   localparam int RS_IDX_W  = $clog2(RS_DEPTH);
   localparam int RS_CNT_W  = RS_IDX_W + 1;
   typedef enum logic [1:0] {OP_NONE, OP_ALLOC, OP_FREE, OP_FLUSH} rs_op_e;
   function automatic int unsigned popcnt(input logic [31:0] v);
      popcnt = 0;
      for (int i = 0; i < 32; i++) popcnt += 32'(v[i]);
   endfunction
endpackage

// File: rtl/rs_slot_alloc_prio_enc.sv
// prio_enc_lsb: lowest-set-bit encoder with a found flag.
module prio_enc_lsb #(
   parameter int W = 8,
   localparam int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          found
);
   always_comb begin
      idx = '0;
      found = |req;
      for (int i = W - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
   end
endmodule

// File: rtl/rs_slot_alloc.sv
// rs_slot_alloc: reservation-station slot bitmap with lowest-free allocation, release, flush and occupancy flags.
module rs_slot_alloc
   import rs_slot_alloc_pkg::*;
#(
   parameter int DEPTH  = RS_DEPTH,
   parameter int MARGIN = RS_MARGIN,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int CNT_W = IDX_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   output logic             alloc_grant,
   output logic [IDX_W-1:0] alloc_idx,
   input  logic             free_valid,
   input  logic [IDX_W-1:0] free_idx,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             free_err
);
   logic [DEPTH-1:0] bm, bm_nxt;
   logic             any_clr, free_ok;
   logic [CNT_W-1:0] cnt_nxt;
   prio_enc_lsb #(.W(DEPTH)) u_enc (.req(~bm), .idx(alloc_idx), .found(any_clr));
   // a slot freed this cycle is absent from the encoder input until the next edge
   always_comb begin
      alloc_grant = alloc_valid & any_clr & ~flush & ~rst;
      free_ok = free_valid & bm[free_idx];
      bm_nxt = flush ? '0 : (bm | (alloc_grant ? DEPTH'(1) << alloc_idx : DEPTH'(0)))
                            & ~(free_ok ? DEPTH'(1) << free_idx : DEPTH'(0));
      cnt_nxt = CNT_W'(popcnt(32'(bm_nxt)));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bm <= '0;
         count <= '0;
         full <= 1'b0;
         empty <= 1'b1;
         free_err <= 1'b0;
      end else begin
         bm <= bm_nxt;
         count <= cnt_nxt;
         full <= (DEPTH - int'(cnt_nxt)) <= MARGIN;
         empty <= cnt_nxt == '0;
         free_err <= free_valid & ~bm[free_idx] & ~flush;
      end
   end
endmodule

// File: tb/tb_rs_slot_alloc.sv
// tb_rs_slot_alloc: scoreboard-driven checks of allocation, release, flush and reset behaviour.
module tb_rs_slot_alloc;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       alloc_valid = 1'b0;
   logic       alloc_grant;
   logic [2:0] alloc_idx;
   logic       free_valid = 1'b0;
   logic [2:0] free_idx = '0;
   logic       flush = 1'b0;
   logic       full, empty, free_err;
   logic [3:0] count;
   int         vectors = 0;
   int         errors = 0;
   typedef struct packed {
      logic       grant;
      logic [2:0] idx;
      logic [3:0] cnt;
      logic       full;
      logic       empty;
      logic       err;
   } obs_t;
   obs_t exp_q[$];
   rs_slot_alloc dut (
      .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_grant(alloc_grant),
      .alloc_idx(alloc_idx), .free_valid(free_valid), .free_idx(free_idx), .flush(flush),
      .full(full), .empty(empty), .count(count), .free_err(free_err)
   );
   always #5 clk = ~clk;
   function automatic obs_t mk(input logic g, input int i, input int c, input logic f, input logic e, input logic r);
      mk = '{grant: g, idx: g ? 3'(i) : 3'd0, cnt: 4'(c), full: f, empty: e, err: r};
   endfunction
   // drive one cycle: combinational outputs sampled just before the edge, registered ones just after
   task automatic step(input logic r, input logic av, input logic fv, input int fi, input logic fl, output obs_t o);
      rst = r;
      alloc_valid = av;
      free_valid = fv;
      free_idx = 3'(fi);
      flush = fl;
      #3;
      o.grant = alloc_grant;
      o.idx = alloc_grant ? alloc_idx : 3'd0;
      @(posedge clk);
      #1;
      o.cnt = count;
      o.full = full;
      o.empty = empty;
      o.err = free_err;
      rst = 1'b0;
      alloc_valid = 1'b0;
      free_valid = 1'b0;
      flush = 1'b0;
   endtask
   task automatic test_reset();
      obs_t o, e;
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
      step(1, 1, 1, 2, 1, o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset: got %h want %h", o, e);
      end
   endtask
   task automatic test_fill();
      obs_t o, e;
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(mk(1, k, k + 1, k >= 6, 0, 0));
         step(0, 1, 0, 0, 0, o);
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            errors++;
            $display("FAIL fill[%0d]: got %h want %h", k, o, e);
         end
      end
   endtask
   task automatic test_overflow();
      obs_t o, e;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(mk(0, 0, 8, 1, 0, 0));
         step(0, 1, 0, 0, 0, o);
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            errors++;
            $display("FAIL overflow[%0d]: got %h want %h", k, o, e);
         end
      end
   endtask
   task automatic test_release_reuse();
      obs_t o, e;
      exp_q.push_back(mk(0, 0, 7, 1, 0, 0));
      exp_q.push_back(mk(1, 3, 8, 1, 0, 0));
      for (int k = 0; k < 2; k++) begin
         step(0, k == 1, k == 0, 3, 0, o);
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            errors++;
            $display("FAIL release_reuse[%0d]: got %h want %h", k, o, e);
         end
      end
   endtask
   task automatic test_simultaneous();
      obs_t o, e;
      step(1, 0, 0, 0, 0, o);
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, k, k + 1, 0, 0, 0));
      exp_q.push_back(mk(1, 4, 4, 0, 0, 0));
      exp_q.push_back(mk(1, 1, 5, 0, 0, 0));
      exp_q.push_back(mk(1, 5, 6, 0, 0, 0));
      exp_q.push_back(mk(1, 6, 7, 1, 0, 1));
      exp_q.push_back(mk(0, 0, 7, 1, 0, 0));
      for (int k = 0; k < 9; k++) begin
         step(0, k != 8, k == 4 || k == 7, k == 4 ? 1 : 6, 0, o);
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            errors++;
            $display("FAIL simultaneous[%0d]: got %h want %h", k, o, e);
         end
      end
   endtask
   task automatic test_bad_free();
      obs_t o, e;
      step(1, 0, 0, 0, 0, o);
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, k, k + 1, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 4, 0, 0, 1));
      exp_q.push_back(mk(0, 0, 4, 0, 0, 0));
      for (int k = 0; k < 6; k++) begin
         step(0, k < 4, k == 4, 6, 0, o);
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            errors++;
            $display("FAIL bad_free[%0d]: got %h want %h", k, o, e);
         end
      end
   endtask
   task automatic test_flush_reset();
      obs_t o, e;
      step(1, 0, 0, 0, 0, o);
      for (int k = 0; k < 5; k++) exp_q.push_back(mk(1, k, k + 1, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
      exp_q.push_back(mk(1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk(1, 1, 2, 0, 0, 0));
      exp_q.push_back(mk(1, 2, 3, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
      exp_q.push_back(mk(1, 0, 1, 0, 0, 0));
      // flush cycle also carries an invalid free that must not raise free_err
      for (int k = 0; k < 11; k++) begin
         step(k == 9, 1, k == 5, 7, k == 5, o);
         e = exp_q.pop_front();
         vectors++;
         if (o !== e) begin
            errors++;
            $display("FAIL flush_reset[%0d]: got %h want %h", k, o, e);
         end
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_overflow();
      test_release_reuse();
      test_simultaneous();
      test_bad_free();
      test_flush_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
